spi_slave: RTL and testbench

//  SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. Peer of spi_master on the other end of the same

---
 rtl/spi_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave -- SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// The peer of spi_master on one SCLK/MOSI/MISO/SS link. SCLK, MOSI and SS are
// synchronised into the clk domain. MOSI is sampled on SCLK rising edges and
// MISO is shifted out on SCLK falling edges. The user side has a one-word TX
// buffer and an RX holding register with a valid/ack handshake.
//
// Parameters:
//   DATA_WIDTH  bits per transfer (default 8)
//   SYNC_STAGES synchroniser depth on sclk, mosi and ss (minimum 2)
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   sclk, mosi   SPI clock and master-out data from the master
//   ss           slave select, active low
//   miso         slave-out data; 1 while deselected
//   tx_data      next word to send
//   tx_load      write tx_data into the TX buffer (only while tx_ready=1)
//   tx_ready     TX buffer empty
//   rx_data      last received word; stable while rx_valid=1
//   rx_valid     rx_data holds an unacknowledged word
//   rx_ack       clears rx_valid
//   busy         a word is being shifted
//   rx_overrun   sticky overrun flag (only with SPI_SLAVE_OVERRUN_EN)
//
// Build option: define SPI_SLAVE_OVERRUN_EN to add rx_overrun and keep the
// unacknowledged word instead of overwriting it.

module spi_slave #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  ss,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ack,
   output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
   ,
   output logic                  rx_overrun
`endif
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_sync;
   logic [SYNC_STAGES-1:0]  mosi_sync;
   logic [SYNC_STAGES-1:0]  ss_sync;
   logic                    sclk_prev;
   logic                    sclk_s;
   logic                    mosi_s;
   logic                    ss_s;
   logic                    sclk_rise;
   logic                    sclk_fall;
   logic [DATA_WIDTH-1:0]   shreg;
   logic [DATA_WIDTH-1:0]   rx_shift;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0]   tx_buf;
   logic                    rx_done;

   // Synchronisers; mosi goes through the same depth as sclk so the bit
   // seen on a detected rise is the one present at the pin edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         mosi_sync <= '1;
         ss_sync   <= '1;
         sclk_prev <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sclk_prev <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         miso     <= 1'b1;
         busy     <= 1'b0;
         shreg    <= '1;
         rx_shift <= '0;
         bit_cnt  <= '0;
         tx_buf   <= '0;
         tx_ready <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_done  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
         rx_overrun <= 1'b0;
`endif
      end else begin
         // User-side TX buffer write; a full buffer ignores tx_load.
         if (tx_load && tx_ready) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end

         // RX handshake. rx_done is the one-cycle-late commit of a finished
         // word; the later assignment lets a commit win over a same-cycle ack.
         rx_done <= 1'b0;
         if (rx_ack) begin
            rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_overrun <= 1'b0;
`endif
         end
         if (rx_done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_valid && !rx_ack) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
            end
`else
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
`endif
         end

         // Deselect aborts whatever is in flight; partial words are dropped.
         if (state != IDLE && ss_s) begin
            state <= IDLE;
            miso  <= 1'b1;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  miso <= 1'b1;
                  busy <= 1'b0;
                  if (!ss_s) state <= LOAD;
               end
               LOAD: begin
                  // tx_ready=0 here means the buffer holds a word; taking it
                  // frees the buffer. The write above cannot fire in that case.
                  if (!tx_ready) begin
                     shreg    <= tx_buf;
                     miso     <= tx_buf[DATA_WIDTH-1];
                     tx_ready <= 1'b1;
                  end else begin
                     shreg <= '1;
                     miso  <= 1'b1;
                  end
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == LAST_BIT) begin
                        rx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                     end
                  end else if (sclk_fall) begin
                     shreg <= {shreg[DATA_WIDTH-2:0], 1'b1};
                     miso  <= shreg[DATA_WIDTH-2];
                  end
               end
               DONE: begin
                  // ss is known low here; a high ss was caught above.
                  if (sclk_fall) state <= LOAD;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sclk;
   logic       mosi;
   logic       ss;
   logic       miso;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_overrun;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [7:0] exp_miso_q[$];
   logic [7:0] exp_rx_q[$];

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk),
      .mosi     (mosi),
      .ss       (ss),
      .miso     (miso),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ack   (rx_ack),
      .busy     (busy)
`ifdef SPI_SLAVE_OVERRUN_EN
      ,
      .rx_overrun (rx_overrun)
`endif
   );

   // Master model: mode 0, MSB first; miso is sampled at each SCLK rise.
   task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
      rx = '0;
      for (int unsigned k = 0; k < nbits; k++) begin
         mosi = tx[7-k];
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         rx = {rx[6:0], miso};
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic ss_select();
      ss = 1'b0;
      repeat (2*HALF) @(negedge clk);
   endtask

   task automatic ss_release();
      repeat (HALF) @(negedge clk);
      ss   = 1'b1;
      mosi = 1'b1;
      repeat (2*HALF) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic ack_rx();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] got;
      rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b1;
      tx_data = '0; tx_load = 1'b0; rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_cnt++; if (miso !== 1'b1) $display("FAIL reset_miso: actual %b required 1", miso); else pass_cnt++;
      chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: actual %b required 1", tx_ready); else pass_cnt++;
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: actual %b required 0", rx_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: actual %b required 0", busy); else pass_cnt++;
      chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: actual %h required 00", rx_data); else pass_cnt++;
      // Start a transfer and reset in the middle of it.
      load_tx(8'h00);
      ss_select();
      chk_cnt++; if (miso !== 1'b0) $display("FAIL midreset_first_bit: actual %b required 0", miso); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL midreset_busy_shift: actual %b required 1", busy); else pass_cnt++;
      spi_bits(8'h0F, 3, got);
      load_tx(8'h5A);
      chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL midreset_tx_full: actual %b required 0", tx_ready); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (miso !== 1'b1) $display("FAIL async_reset_miso: actual %b required 1", miso); else pass_cnt++;
      chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL async_reset_tx_ready: actual %b required 1", tx_ready); else pass_cnt++;
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL async_reset_rx_valid: actual %b required 0", rx_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL async_reset_busy: actual %b required 0", busy); else pass_cnt++;
      @(negedge clk);
      ss = 1'b1; mosi = 1'b1; sclk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_byte();
      logic [7:0] got, want;
      load_tx(8'hA5);
      exp_miso_q.push_back(8'hA5);
      exp_rx_q.push_back(8'h3C);
      ss_select();
      spi_bits(8'h3C, 8, got);
      // Four clk after the last rise: the rx_valid latency bound.
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL single_rx_valid_latency: actual %b required 1", rx_valid); else pass_cnt++;
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL single_master_rx: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL single_rx_data: actual %h required %h", rx_data, want); else pass_cnt++;
      ss_release();
      ack_rx();
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_ack_clear: actual %b required 0", rx_valid); else pass_cnt++;
   endtask

   task automatic test_empty_tx();
      logic [7:0] got, want;
      int unsigned n;
      chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL empty_tx_ready: actual %b required 1", tx_ready); else pass_cnt++;
      exp_miso_q.push_back(8'hFF);
      exp_rx_q.push_back(8'h00);
      ss_select();
      spi_bits(8'h00, 8, got);
      n = 0;
      while (rx_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL empty_rx_valid: actual %b required 1", rx_valid); else pass_cnt++;
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL empty_master_rx: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL empty_rx_data: actual %h required %h", rx_data, want); else pass_cnt++;
      ss_release();
      ack_rx();
   endtask

   task automatic test_back_to_back();
      logic [7:0] got, want;
      load_tx(8'h11);
      exp_miso_q.push_back(8'h11);
      load_tx(8'h99);   // buffer full: must be ignored
      chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL b2b_tx_full: actual %b required 0", tx_ready); else pass_cnt++;
      ss_select();
      chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL b2b_tx_taken: actual %b required 1", tx_ready); else pass_cnt++;
      load_tx(8'h22);
      exp_miso_q.push_back(8'h22);
      exp_rx_q.push_back(8'hC3);
      exp_rx_q.push_back(8'h5A);
      spi_bits(8'hC3, 8, got);
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_rx_valid_1: actual %b required 1", rx_valid); else pass_cnt++;
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL b2b_master_rx_1: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL b2b_rx_data_1: actual %h required %h", rx_data, want); else pass_cnt++;
      ack_rx();
      repeat (2*HALF) @(negedge clk);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_second: actual %b required 1", busy); else pass_cnt++;
      spi_bits(8'h5A, 8, got);
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_rx_valid_2: actual %b required 1", rx_valid); else pass_cnt++;
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL b2b_master_rx_2: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL b2b_rx_data_2: actual %h required %h", rx_data, want); else pass_cnt++;
      ss_release();
      ack_rx();
   endtask

   task automatic test_abort();
      logic [7:0] got, want;
      load_tx(8'h99);
      ss_select();
      spi_bits(8'hF0, 4, got);
      chk_cnt++; if (got !== 8'h09) $display("FAIL abort_partial_bits: actual %h required 09", got); else pass_cnt++;
      ss = 1'b1; mosi = 1'b1;
      repeat (2*HALF) @(negedge clk);
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL abort_no_rx_valid: actual %b required 0", rx_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: actual %b required 0", busy); else pass_cnt++;
      chk_cnt++; if (miso !== 1'b1) $display("FAIL abort_miso: actual %b required 1", miso); else pass_cnt++;
      chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL abort_tx_ready: actual %b required 1", tx_ready); else pass_cnt++;
      load_tx(8'hE7);
      exp_miso_q.push_back(8'hE7);
      exp_rx_q.push_back(8'h81);
      ss_select();
      spi_bits(8'h81, 8, got);
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL abort_next_rx_valid: actual %b required 1", rx_valid); else pass_cnt++;
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL abort_next_master_rx: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL abort_next_rx_data: actual %h required %h", rx_data, want); else pass_cnt++;
      ss_release();
      ack_rx();
   endtask

   task automatic test_overrun();
      logic [7:0] got, want;
      exp_miso_q.push_back(8'hFF);
      exp_miso_q.push_back(8'hFF);
      exp_rx_q.push_back(8'h66);
      ss_select();
      spi_bits(8'h66, 8, got);
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL ovr_master_rx_1: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL ovr_rx_data_1: actual %h required %h", rx_data, want); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
      exp_rx_q.push_back(8'h66);
`else
      exp_rx_q.push_back(8'h77);
`endif
      repeat (2*HALF) @(negedge clk);
      spi_bits(8'h77, 8, got);
      repeat (2) @(negedge clk);
      want = exp_miso_q.pop_front();
      chk_cnt++; if (got !== want) $display("FAIL ovr_master_rx_2: actual %h required %h", got, want); else pass_cnt++;
      want = exp_rx_q.pop_front();
      chk_cnt++; if (rx_data !== want) $display("FAIL ovr_rx_data_2: actual %h required %h", rx_data, want); else pass_cnt++;
      chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_rx_valid_held: actual %b required 1", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
      chk_cnt++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag_set: actual %b required 1", rx_overrun); else pass_cnt++;
`endif
      ss_release();
      ack_rx();
      chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_ack_clear: actual %b required 0", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
      chk_cnt++; if (rx_overrun !== 1'b0) $display("FAIL ovr_flag_clear: actual %b required 0", rx_overrun); else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_empty_tx();
      test_back_to_back();
      test_abort();
      test_overrun();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual still running, required finished");
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
